// File: rtl/ooo_sram_pkg.sv
// Shared types and helpers for the two-port cache SRAM model.
// The mask merge is shared by both read-forwarding paths and the write path.
package ooo_sram_pkg;

    typedef enum logic {
        INIT,
        READY
    } sram_state_t;

    localparam int SRAM_MAX_DW = 1024;
    localparam int SRAM_MAX_NM = 1024;
    localparam int SRAM_IDX_W  = 10;

    // Overlay the mask-selected slices of new_row onto old_row.
    function automatic logic [SRAM_MAX_DW-1:0] mask_merge(
        input logic [SRAM_MAX_DW-1:0] old_row,
        input logic [SRAM_MAX_DW-1:0] new_row,
        input logic [SRAM_MAX_NM-1:0] mask,
        input int                     gran
    );
        logic [SRAM_MAX_DW-1:0] res;
        logic [SRAM_IDX_W-1:0]  bi;
        logic [SRAM_IDX_W-1:0]  mi;
        res = old_row;
        for (int i = 0; i < SRAM_MAX_DW; i++) begin
            bi = SRAM_IDX_W'(i);
            mi = SRAM_IDX_W'(i / gran);
            if (mask[mi]) begin
                res[bi] = new_row[bi];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ooo_sram_2p_array.sv
// Two-port behavioural SRAM: port A read/write, port B read-only.
// Write-first forwarding, optional output flop, post-reset init sweep.
import ooo_sram_pkg::*;

module ooo_sram_2p_array #(
    parameter int                    DATA_WIDTH    = 256,
    parameter int                    ADDR_WIDTH    = 5,
    parameter int                    WMASK_GRAN    = 8,
    parameter int                    OUT_REG       = 0,
    parameter int                    INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    localparam int                   NUM_WMASKS    = DATA_WIDTH / WMASK_GRAN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy,
    input  logic                  a_csb,
    input  logic                  a_web,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_rvalid,
    input  logic                  b_csb,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_rvalid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    sram_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  ready;

    logic [1:0]            cs_w;
    logic [1:0]            web_w;
    logic [ADDR_WIDTH-1:0] addr_w [2];

    logic [NUM_WMASKS-1:0] wmask_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  a_wr_pend;
    logic [ADDR_WIDTH-1:0] a_waddr;
    logic [DATA_WIDTH-1:0] a_wrow;

    logic [DATA_WIDTH-1:0] dout_w [2];
    logic [1:0]            rvalid_w;

    assign ready     = (state_q == READY);
    assign init_busy = (state_q == INIT);

    // Requests are dropped, not queued, while the sweep runs.
    assign cs_w      = {~b_csb, ~a_csb} & {2{ready}};
    assign web_w     = {1'b1, a_web};
    assign addr_w[0] = a_addr;
    assign addr_w[1] = b_addr;

    // Init FSM state and sweep pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_ON_RESET != 0) ? INIT : READY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Sweep one row per cycle, leave after the last row.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                ptr_d = ptr_q;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // Port A write payload, captured with the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wmask_q <= '0;
            din_q   <= '0;
        end else if (cs_w[0]) begin
            wmask_q <= a_wmask;
            din_q   <= a_din;
        end
    end

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_port
            logic                  req_q;
            logic                  web_q;
            logic [ADDR_WIDTH-1:0] addr_q;
            logic [DATA_WIDTH-1:0] row_m;
            logic                  rv_pre;

            // Capture the request; the accept flag clears when idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    req_q  <= 1'b0;
                    web_q  <= 1'b1;
                    addr_q <= '0;
                end else begin
                    req_q <= cs_w[p];
                    if (cs_w[p]) begin
                        web_q  <= web_w[p];
                        addr_q <= addr_w[p];
                    end
                end
            end

            // Row view with a pending port A write overlaid.
            always_comb begin
                row_m = mem_q[addr_q];
                if (a_wr_pend && (a_waddr == addr_q)) begin
                    row_m = DATA_WIDTH'(mask_merge(
                        SRAM_MAX_DW'(mem_q[addr_q]),
                        SRAM_MAX_DW'(din_q),
                        SRAM_MAX_NM'(wmask_q),
                        WMASK_GRAN));
                end
            end

            assign rv_pre = req_q & web_q;

            if (OUT_REG == 0) begin : g_comb
                logic seen_q;

                // Remember any accepted request so dout reads 0 until then.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        seen_q <= 1'b0;
                    end else if (cs_w[p]) begin
                        seen_q <= 1'b1;
                    end
                end

                assign rvalid_w[p] = rv_pre;
                assign dout_w[p]   = seen_q ? row_m : '0;
            end else begin : g_flop
                logic                  rv_q;
                logic [DATA_WIDTH-1:0] dout_q;

                // Output flop loads only on a valid read, else holds.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        rv_q   <= 1'b0;
                        dout_q <= '0;
                    end else begin
                        rv_q <= rv_pre;
                        if (rv_pre) begin
                            dout_q <= row_m;
                        end
                    end
                end

                assign rvalid_w[p] = rv_q;
                assign dout_w[p]   = dout_q;
            end
        end
    endgenerate

    assign a_wr_pend = g_port[0].req_q & ~g_port[0].web_q;
    assign a_waddr   = g_port[0].addr_q;
    assign a_wrow    = g_port[0].row_m;

    // Row writes: sweep rows during init, else commit port A.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem_q[ptr_q] <= INIT_VALUE;
        end else if (a_wr_pend) begin
            mem_q[a_waddr] <= a_wrow;
        end
    end

    assign a_dout   = dout_w[0];
    assign b_dout   = dout_w[1];
    assign a_rvalid = rvalid_w[0];
    assign b_rvalid = rvalid_w[1];

endmodule

// File: tb/tb_ooo_sram_2p_array.sv
// Bench for ooo_sram_2p_array: a 256-bit comb-out instance and a
// 64-bit, 32-bit-granule, registered-out instance.
module tb_ooo_sram_2p_array;

    localparam logic [255:0] INIT0 = {32{8'h3C}};
    localparam logic [63:0]  INIT1 = 64'h0123_4567_89AB_CDEF;

    typedef struct {
        int           cyc;
        logic [255:0] d;
    } exp_t;

    typedef struct {
        logic         a_en;
        logic         a_wr;
        logic [4:0]   a_addr;
        logic [31:0]  a_mask;
        logic [255:0] a_din;
        logic [255:0] exp_a;
        logic         b_en;
        logic [4:0]   b_addr;
        logic [255:0] exp_b;
    } vec_t;

    localparam int NV = 11;

    logic clk;
    logic rst_n;

    logic         busy0, a0_csb, a0_web, a0_rvalid, b0_csb, b0_rvalid;
    logic [4:0]   a0_addr, b0_addr;
    logic [31:0]  a0_wmask;
    logic [255:0] a0_din, a0_dout, b0_dout;

    logic         busy1, a1_csb, a1_web, a1_rvalid, b1_csb, b1_rvalid;
    logic [4:0]   a1_addr, b1_addr;
    logic [1:0]   a1_wmask;
    logic [63:0]  a1_din, a1_dout, b1_dout;

    exp_t sq [4][$];
    vec_t tv [NV];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n0, n1;

    ooo_sram_2p_array #(
        .DATA_WIDTH(256), .ADDR_WIDTH(5), .WMASK_GRAN(8),
        .OUT_REG(0), .INIT_ON_RESET(1), .INIT_VALUE(INIT0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy0),
        .a_csb(a0_csb), .a_web(a0_web), .a_addr(a0_addr),
        .a_wmask(a0_wmask), .a_din(a0_din), .a_dout(a0_dout),
        .a_rvalid(a0_rvalid), .b_csb(b0_csb), .b_addr(b0_addr),
        .b_dout(b0_dout), .b_rvalid(b0_rvalid)
    );

    ooo_sram_2p_array #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .WMASK_GRAN(32),
        .OUT_REG(1), .INIT_ON_RESET(1), .INIT_VALUE(INIT1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy1),
        .a_csb(a1_csb), .a_web(a1_web), .a_addr(a1_addr),
        .a_wmask(a1_wmask), .a_din(a1_din), .a_dout(a1_dout),
        .a_rvalid(a1_rvalid), .b_csb(b1_csb), .b_addr(b1_addr),
        .b_dout(b1_dout), .b_rvalid(b1_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic push(input int p, input int c, input logic [255:0] d);
        exp_t e;
        e.cyc = c;
        e.d   = d;
        sq[p].push_back(e);
    endtask

    task automatic mon(input int p, input logic rv, input logic [255:0] d);
        exp_t e;
        if (rv) begin
            total++;
            if (sq[p].size() == 0) begin
                bad++;
                $display("FAIL rvalid_spurious port=%0d cyc=%0d", p, cyc);
            end else begin
                e = sq[p].pop_front();
                if (e.cyc != cyc || d !== e.d) begin
                    bad++;
                    $display("FAIL rdata port=%0d cyc=%0d act=%h exp_cyc=%0d exp=%h",
                             p, cyc, d, e.cyc, e.d);
                end
            end
        end else if (sq[p].size() != 0 && sq[p][0].cyc <= cyc) begin
            total++;
            bad++;
            $display("FAIL rvalid_missing port=%0d cyc=%0d exp_cyc=%0d",
                     p, cyc, sq[p][0].cyc);
            void'(sq[p].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, a0_rvalid, a0_dout);
        mon(1, b0_rvalid, b0_dout);
        mon(2, a1_rvalid, 256'(a1_dout));
        mon(3, b1_rvalid, 256'(b1_dout));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a0_csb = 1'b1;
        b0_csb = 1'b1;
        a1_csb = 1'b1;
        b1_csb = 1'b1;
    endtask

    // Count negedges with busy high; release requests once both are ready.
    task automatic count_busy(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy0) c0++;
            if (busy1) c1++;
            if (!busy0 && !busy1) begin
                idle_all();
                break;
            end
        end
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b1, 5'd5, 32'h0000_000F, {32{8'hAA}}, 256'h0,
                   1'b0, 5'd0, 256'h0};
        tv[1]  = '{1'b1, 1'b0, 5'd5, 32'h0, 256'h0, {{28{8'h3C}}, {4{8'hAA}}},
                   1'b1, 5'd5, {{28{8'h3C}}, {4{8'hAA}}}};
        tv[2]  = '{1'b1, 1'b1, 5'd3, 32'h0000_0001, {32{8'h5C}}, 256'h0,
                   1'b1, 5'd3, {{31{8'h3C}}, 8'h5C}};
        tv[3]  = '{1'b1, 1'b0, 5'd3, 32'h0, 256'h0, {{31{8'h3C}}, 8'h5C},
                   1'b1, 5'd4, INIT0};
        tv[4]  = '{1'b1, 1'b1, 5'd31, 32'h8000_0000, {32{8'hE1}}, 256'h0,
                   1'b1, 5'd31, {8'hE1, {31{8'h3C}}}};
        tv[5]  = '{1'b1, 1'b1, 5'd0, 32'h0, {32{8'hFF}}, 256'h0,
                   1'b1, 5'd0, INIT0};
        tv[6]  = '{1'b1, 1'b0, 5'd0, 32'h0, 256'h0, INIT0,
                   1'b1, 5'd31, {8'hE1, {31{8'h3C}}}};
        tv[7]  = '{1'b1, 1'b1, 5'd5, 32'h0000_00F0, {32{8'h77}}, 256'h0,
                   1'b1, 5'd5, {{24{8'h3C}}, {4{8'h77}}, {4{8'hAA}}}};
        tv[8]  = '{1'b1, 1'b0, 5'd5, 32'h0, 256'h0,
                   {{24{8'h3C}}, {4{8'h77}}, {4{8'hAA}}},
                   1'b0, 5'd0, 256'h0};
        tv[9]  = '{1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF, {32{8'h01}}, 256'h0,
                   1'b1, 5'd5, {32{8'h01}}};
        tv[10] = '{1'b1, 1'b0, 5'd5, 32'h0, 256'h0, {32{8'h01}},
                   1'b1, 5'd3, {{31{8'h3C}}, 8'h5C}};

        rst_n = 1'b0;
        idle_all();
        a0_web = 1'b1; a0_addr = '0; a0_wmask = '0; a0_din = '0; b0_addr = '0;
        a1_web = 1'b1; a1_addr = '0; a1_wmask = '0; a1_din = '0; b1_addr = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a0_rvalid", 256'(a0_rvalid), 256'd0);
        check("rst_b0_rvalid", 256'(b0_rvalid), 256'd0);
        check("rst_a0_dout", a0_dout, 256'd0);
        check("rst_b0_dout", b0_dout, 256'd0);
        check("rst_busy0", 256'(busy0), 256'd1);
        check("rst_a1_dout", 256'(a1_dout), 256'd0);
        check("rst_b1_dout", 256'(b1_dout), 256'd0);
        check("rst_busy1", 256'(busy1), 256'd1);

        step();
        rst_n = 1'b1;
        count_busy(n0, n1);
        check("init_cycles0", 256'(n0), 256'd32);
        check("init_cycles1", 256'(n1), 256'd32);

        // Every row reads back INIT_VALUE after the sweep.
        for (int r = 0; r < 32; r++) begin
            step();
            b0_csb = 1'b0; b0_addr = 5'(r);
            push(1, cyc + 1, INIT0);
            b1_csb = 1'b0; b1_addr = 5'(r);
            push(3, cyc + 2, 256'(INIT1));
        end
        step();
        idle_all();
        repeat (3) step();

        // Vector table on the comb-out instance.
        for (int i = 0; i < NV; i++) begin
            a0_csb   = !tv[i].a_en;
            a0_web   = !tv[i].a_wr;
            a0_addr  = tv[i].a_addr;
            a0_wmask = tv[i].a_mask;
            a0_din   = tv[i].a_din;
            b0_csb   = !tv[i].b_en;
            b0_addr  = tv[i].b_addr;
            if (tv[i].a_en && !tv[i].a_wr) push(0, cyc + 1, tv[i].exp_a);
            if (tv[i].b_en) push(1, cyc + 1, tv[i].exp_b);
            step();
        end
        idle_all();
        repeat (3) step();

        // Registered-out instance: 32-bit granule write, then reads.
        a1_csb = 1'b0; a1_web = 1'b0; a1_addr = 5'd2;
        a1_wmask = 2'b10; a1_din = 64'hDEAD_BEEF_0000_0001;
        step();
        a1_web = 1'b1;
        push(2, cyc + 2, 256'(64'hDEAD_BEEF_89AB_CDEF));
        b1_csb = 1'b0; b1_addr = 5'd2;
        push(3, cyc + 2, 256'(64'hDEAD_BEEF_89AB_CDEF));
        step();
        a1_csb = 1'b1;
        b1_addr = 5'd7;
        push(3, cyc + 2, 256'(INIT1));
        step();
        idle_all();
        repeat (4) step();
        check("b1_hold_dout", 256'(b1_dout), 256'(INIT1));
        check("b1_hold_rvalid", 256'(b1_rvalid), 256'd0);

        // Write with B read of the same row in the same cycle.
        a1_csb = 1'b0; a1_web = 1'b0; a1_addr = 5'd9;
        a1_wmask = 2'b01; a1_din = 64'hFFFF_FFFF_A5A5_A5A5;
        b1_csb = 1'b0; b1_addr = 5'd9;
        push(3, cyc + 2, 256'(64'h0123_4567_A5A5_A5A5));
        step();
        idle_all();
        repeat (4) step();
        check("a1_hold_after_wr", 256'(a1_dout), 256'(64'hDEAD_BEEF_89AB_CDEF));

        // Reset mid-sweep, then requests held through the new sweep.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        rst_n = 1'b0;
        a0_csb = 1'b0; a0_web = 1'b0; a0_addr = 5'd0;
        a0_wmask = '1; a0_din = '1;
        b0_csb = 1'b0; b0_addr = 5'd9;
        a1_csb = 1'b0; a1_web = 1'b0; a1_addr = 5'd0;
        a1_wmask = '1; a1_din = '1;
        b1_csb = 1'b0; b1_addr = 5'd9;
        step();
        rst_n = 1'b1;
        count_busy(n0, n1);
        check("resweep_cycles0", 256'(n0), 256'd32);
        check("resweep_cycles1", 256'(n1), 256'd32);

        step();
        a0_csb = 1'b0; a0_web = 1'b1; a0_addr = 5'd0;
        push(0, cyc + 1, INIT0);
        b0_csb = 1'b0; b0_addr = 5'd9;
        push(1, cyc + 1, INIT0);
        a1_csb = 1'b0; a1_web = 1'b1; a1_addr = 5'd0;
        push(2, cyc + 2, 256'(INIT1));
        b1_csb = 1'b0; b1_addr = 5'd9;
        push(3, cyc + 2, 256'(INIT1));
        step();
        idle_all();
        repeat (5) step();

        for (int p = 0; p < 4; p++) begin
            total++;
            if (sq[p].size() != 0) begin
                bad++;
                $display("FAIL queue_drain port=%0d left=%0d exp=0",
                         p, sq[p].size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
